// File: rtl/sm_transition_checker.sv
// Protocol monitor for the 4-bit state-machine stream: flags illegal arcs and
// out-of-range states, counts errors (saturating) and records per-arc coverage.
module sm_transition_checker #(
   parameter int CNT_W    = 16,
   parameter int NUM_ARCS = 19
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          state,
   input  logic                clr_stats,
   output logic                err,
   output logic [3:0]          err_prev,
   output logic [3:0]          err_cur,
   output logic [CNT_W-1:0]    err_count,
   output logic                bad_state,
   output logic [NUM_ARCS-1:0] cov_hits,
   output logic                all_covered
);

   localparam logic [4:0] ARC_NONE = 5'd31;

   logic [3:0]          prev_q,     prev_d;
   logic                err_q,      err_d;
   logic                bad_q,      bad_d;
   logic [3:0]          err_prev_q, err_prev_d;
   logic [3:0]          err_cur_q,  err_cur_d;
   logic [CNT_W-1:0]    cnt_q,      cnt_d;
   logic [NUM_ARCS-1:0] cov_q,      cov_d;
   logic                allcov_q,   allcov_d;

   logic [4:0] arc_idx;
   logic       arc_legal;

   // Maps (source, destination) to its coverage bit, or ARC_NONE if illegal.
   function automatic logic [4:0] arc_lookup(input logic [3:0] src, input logic [3:0] dst);
      logic [4:0] idx;
      case ({src, dst})
         8'h01: idx = 5'd0;
         8'h12: idx = 5'd1;
         8'h14: idx = 5'd2;
         8'h23: idx = 5'd3;
         8'h31: idx = 5'd4;
         8'h35: idx = 5'd5;
         8'h45: idx = 5'd6;
         8'h51: idx = 5'd7;
         8'h56: idx = 5'd8;
         8'h67: idx = 5'd9;
         8'h70: idx = 5'd10;
         8'h78: idx = 5'd11;
         8'h82: idx = 5'd12;
         8'h84: idx = 5'd13;
         8'h89: idx = 5'd14;
         8'h8A: idx = 5'd15;
         8'h90: idx = 5'd16;
         8'hA0: idx = 5'd17;
         8'hB4, 8'hC4, 8'hD4, 8'hE4, 8'hF4: idx = 5'd18;
         default: idx = ARC_NONE;
      endcase
      return idx;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   assign arc_idx   = arc_lookup(prev_q, state);
   assign arc_legal = (arc_idx != ARC_NONE);

   always_comb begin
      prev_d     = state;
      err_d      = !arc_legal;
      bad_d      = (state > 4'd10);
      err_prev_d = err_prev_q;
      err_cur_d  = err_cur_q;
      cnt_d      = cnt_q;
      cov_d      = cov_q;
      allcov_d   = &cov_q;

      if (!arc_legal) begin
         err_prev_d = prev_q;
         err_cur_d  = state;
      end

      // Clearing the statistics wins over this edge's count/coverage update.
      if (clr_stats) begin
         cnt_d    = '0;
         cov_d    = '0;
         allcov_d = 1'b0;
      end else if (!arc_legal) begin
         cnt_d = sat_inc(cnt_q);
      end else begin
         cov_d = cov_q | (NUM_ARCS'(1) << arc_idx);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q     <= 4'd0;
         err_q      <= 1'b0;
         bad_q      <= 1'b0;
         err_prev_q <= 4'd0;
         err_cur_q  <= 4'd0;
         cnt_q      <= '0;
         cov_q      <= '0;
         allcov_q   <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         err_q      <= err_d;
         bad_q      <= bad_d;
         err_prev_q <= err_prev_d;
         err_cur_q  <= err_cur_d;
         cnt_q      <= cnt_d;
         cov_q      <= cov_d;
         allcov_q   <= allcov_d;
      end
   end

   assign err         = err_q;
   assign bad_state   = bad_q;
   assign err_prev    = err_prev_q;
   assign err_cur     = err_cur_q;
   assign err_count   = cnt_q;
   assign cov_hits    = cov_q;
   assign all_covered = allcov_q;

endmodule

// File: tb/tb_sm_transition_checker.sv
// Bench for sm_transition_checker: vector table, directed corner sequences and
// random traffic against a table-driven reference model.
module tb_sm_transition_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  state = 4'd0;
   logic        clr_stats = 1'b0;

   logic        err, bad_state, all_covered;
   logic [3:0]  err_prev, err_cur;
   logic [15:0] err_count;
   logic [18:0] cov_hits;

   logic        s_err, s_bad, s_all;
   logic [3:0]  s_prev, s_cur;
   logic [1:0]  s_count;
   logic [18:0] s_cov;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sm_transition_checker #(.CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .state(state), .clr_stats(clr_stats),
      .err(err), .err_prev(err_prev), .err_cur(err_cur), .err_count(err_count),
      .bad_state(bad_state), .cov_hits(cov_hits), .all_covered(all_covered));

   sm_transition_checker #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .state(state), .clr_stats(clr_stats),
      .err(s_err), .err_prev(s_prev), .err_cur(s_cur), .err_count(s_count),
      .bad_state(s_bad), .cov_hits(s_cov), .all_covered(s_all));

   // Legal arcs as (source, destination) lists; list position is the cov bit.
   int srcs [18] = '{0,1,1,2,3,3,4,5,5,6,7,7,8,8, 8, 8,9,10};
   int dsts [18] = '{1,2,4,3,1,5,5,1,6,7,0,8,2,4,9,10,0, 0};

   int          m_prev = 0;
   bit          m_err = 0, m_bad = 0, m_all = 0;
   int          m_ep = 0, m_ec = 0, m_cnt = 0, m_cnt2 = 0;
   logic [18:0] m_cov = '0;

   function automatic int arc_of(int p, int s);
      for (int i = 0; i < 18; i++)
         if (srcs[i] == p && dsts[i] == s) return i;
      if (p >= 11 && s == 4) return 18;
      return -1;
   endfunction

   task automatic model_edge(input logic r, input logic c, input int s);
      int a;
      if (r) begin
         m_prev = 0; m_err = 0; m_bad = 0; m_ep = 0; m_ec = 0;
         m_cnt = 0; m_cnt2 = 0; m_cov = '0; m_all = 0;
         return;
      end
      a     = arc_of(m_prev, s);
      m_err = (a < 0);
      m_bad = (s > 10);
      if (m_err) begin
         m_ep = m_prev;
         m_ec = s;
      end
      if (c) begin
         m_cnt = 0; m_cnt2 = 0; m_cov = '0; m_all = 0;
      end else begin
         m_all = (m_cov == {19{1'b1}});
         if (m_err) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end else begin
            m_cov[a] = 1'b1;
         end
      end
      m_prev = s;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic c, input logic [3:0] s);
      rst = r; clr_stats = c; state = s;
      @(posedge clk);
      model_edge(r, c, int'(s));
      #1;
      chk("err",         {31'b0, err},         {31'b0, m_err});
      chk("bad_state",   {31'b0, bad_state},   {31'b0, m_bad});
      chk("err_prev",    {28'b0, err_prev},    m_ep);
      chk("err_cur",     {28'b0, err_cur},     m_ec);
      chk("err_count",   {16'b0, err_count},   m_cnt);
      chk("sat_count",   {30'b0, s_count},     m_cnt2);
      chk("cov_hits",    {13'b0, cov_hits},    {13'b0, m_cov});
      chk("all_covered", {31'b0, all_covered}, {31'b0, m_all});
   endtask

   typedef struct packed {
      logic       r;
      logic       c;
      logic [3:0] st;
      logic       e_err;
      logic       e_bad;
      logic [7:0] e_cnt;
      logic [3:0] e_prev;
      logic [3:0] e_cur;
   } vec_t;

   vec_t vecs [20];

   logic [3:0] cover_seq [30] = '{5,1,2,3,5,6,7,8,2,3,5,6,7,8,4,5,6,7,8,9,0,1,2,3,5,6,7,8,10,0};

   initial begin
      vecs = '{
         '{1'b1,1'b0,4'd0, 1'b0,1'b0,8'd0,4'd0,4'd0},
         '{1'b1,1'b0,4'd0, 1'b0,1'b0,8'd0,4'd0,4'd0},
         '{1'b0,1'b0,4'd1, 1'b0,1'b0,8'd0,4'd0,4'd0},
         '{1'b0,1'b0,4'd2, 1'b0,1'b0,8'd0,4'd0,4'd0},
         '{1'b0,1'b0,4'd3, 1'b0,1'b0,8'd0,4'd0,4'd0},
         '{1'b0,1'b0,4'd1, 1'b0,1'b0,8'd0,4'd0,4'd0},
         '{1'b0,1'b0,4'd4, 1'b0,1'b0,8'd0,4'd0,4'd0},
         '{1'b0,1'b0,4'd5, 1'b0,1'b0,8'd0,4'd0,4'd0},
         '{1'b0,1'b0,4'd6, 1'b0,1'b0,8'd0,4'd0,4'd0},
         '{1'b0,1'b0,4'd7, 1'b0,1'b0,8'd0,4'd0,4'd0},
         '{1'b0,1'b0,4'd0, 1'b0,1'b0,8'd0,4'd0,4'd0},
         '{1'b0,1'b0,4'd1, 1'b0,1'b0,8'd0,4'd0,4'd0},
         '{1'b0,1'b0,4'd2, 1'b0,1'b0,8'd0,4'd0,4'd0},
         '{1'b0,1'b0,4'd4, 1'b1,1'b0,8'd1,4'd2,4'd4},
         '{1'b0,1'b0,4'd5, 1'b0,1'b0,8'd1,4'd2,4'd4},
         '{1'b0,1'b0,4'd6, 1'b0,1'b0,8'd1,4'd2,4'd4},
         '{1'b0,1'b0,4'd7, 1'b0,1'b0,8'd1,4'd2,4'd4},
         '{1'b0,1'b0,4'd8, 1'b0,1'b0,8'd1,4'd2,4'd4},
         '{1'b0,1'b0,4'd11,1'b1,1'b1,8'd2,4'd8,4'd11},
         '{1'b0,1'b0,4'd4, 1'b0,1'b0,8'd2,4'd8,4'd11}
      };

      for (int i = 0; i < 20; i++) begin
         step(vecs[i].r, vecs[i].c, vecs[i].st);
         chk("vec_err",   {31'b0, err},        {31'b0, vecs[i].e_err});
         chk("vec_bad",   {31'b0, bad_state},  {31'b0, vecs[i].e_bad});
         chk("vec_count", {16'b0, err_count},  {24'b0, vecs[i].e_cnt});
         chk("vec_eprev", {28'b0, err_prev},   {28'b0, vecs[i].e_prev});
         chk("vec_ecur",  {28'b0, err_cur},    {28'b0, vecs[i].e_cur});
         if (i == 10) chk("vec_cov_first", {13'b0, cov_hits}, 32'h0000_075F);
         if (i == 19) chk("vec_cov_bit18", {31'b0, cov_hits[18]}, 32'd1);
      end

      // Close coverage on every remaining arc; the last one is 10->0.
      for (int i = 0; i < 30; i++) step(1'b0, 1'b0, cover_seq[i]);
      chk("cov_full",      {13'b0, cov_hits},    32'h0007_FFFF);
      chk("allcov_lag",    {31'b0, all_covered}, 32'd0);
      step(1'b0, 1'b0, 4'd1);
      chk("allcov_set",    {31'b0, all_covered}, 32'd1);
      // clr_stats on a legal 1->2 edge: that arc must not be recorded.
      step(1'b0, 1'b1, 4'd2);
      chk("clr_cov",       {13'b0, cov_hits},    32'd0);
      chk("clr_allcov",    {31'b0, all_covered}, 32'd0);
      chk("clr_count",     {16'b0, err_count},   32'd0);
      step(1'b0, 1'b0, 4'd3);
      chk("post_clr_cov",  {13'b0, cov_hits},    32'h0000_0008);

      // Five self-loops on 3: small counter pins at 3, err held high.
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 4'd3);
         chk("selfloop_err", {31'b0, s_err}, 32'd1);
      end
      chk("sat_count_3",   {30'b0, s_count},   32'd3);
      chk("wide_count_5",  {16'b0, err_count}, 32'd5);

      // Mid-run reset held two edges with state=6, released into state 1.
      step(1'b0, 1'b0, 4'd5);
      step(1'b0, 1'b0, 4'd6);
      step(1'b1, 1'b0, 4'd6);
      step(1'b1, 1'b1, 4'd6);
      chk("rst_err",   {31'b0, err},       32'd0);
      chk("rst_count", {16'b0, err_count}, 32'd0);
      chk("rst_cov",   {13'b0, cov_hits},  32'd0);
      chk("rst_eprev", {28'b0, err_prev},  32'd0);
      step(1'b0, 1'b0, 4'd1);
      chk("rel_err",   {31'b0, err},       32'd0);
      chk("rel_cov",   {13'b0, cov_hits},  32'd1);

      // Random traffic, mostly legal successors with injected faults.
      for (int n = 0; n < 600; n++) begin
         logic [3:0] nxt;
         logic       r, c;
         int         cand [$];
         cand = {};
         for (int i = 0; i < 18; i++) if (srcs[i] == m_prev) cand.push_back(dsts[i]);
         if (m_prev >= 11) cand.push_back(4);
         if ($urandom_range(0, 99) < 80 && cand.size() > 0)
            nxt = 4'(cand[$urandom_range(0, cand.size() - 1)]);
         else
            nxt = 4'($urandom_range(0, 15));
         r = ($urandom_range(0, 99) < 2);
         c = ($urandom_range(0, 99) < 3);
         step(r, c, r ? 4'd0 : nxt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
